// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin arbiter that merges NB_MASTER AXI read-address channels into one slave port.
// R beats are routed back to the requesting master using the index bits prepended to the ID.
module axi_ar_rr_arbiter #(
    parameter int NB_MASTER      = 2,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 1,
    parameter int MAX_OUTST      = 4,
    localparam int IDX_W         = $clog2(NB_MASTER),
    localparam int SID_W         = AXI_ID_WIDTH + IDX_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NB_MASTER-1:0]                     m_ar_valid,
    output logic [NB_MASTER-1:0]                     m_ar_ready,
    input  logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] m_ar_addr,
    input  logic [NB_MASTER-1:0][AXI_ID_WIDTH-1:0]   m_ar_id,
    output logic                                     s_ar_valid,
    input  logic                                     s_ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0]                s_ar_addr,
    output logic [SID_W-1:0]                         s_ar_id,
    input  logic                                     s_r_valid,
    output logic                                     s_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0]                s_r_data,
    input  logic [SID_W-1:0]                         s_r_id,
    input  logic                                     s_r_last,
    output logic [NB_MASTER-1:0]                     m_r_valid,
    input  logic [NB_MASTER-1:0]                     m_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]                m_r_data,
    output logic [AXI_ID_WIDTH-1:0]                  m_r_id,
    output logic                                     m_r_last,
    output logic                                     route_err_o
);

    // state | meaning
    // EMPTY | output buffer holds no AR
    // FULL  | output buffer holds an AR, s_ar_valid asserted
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    buf_state_t                           state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]            addr_q, addr_d;
    logic [SID_W-1:0]                     id_q, id_d;
    logic [IDX_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [NB_MASTER-1:0][CNT_W-1:0]      outst_q, outst_d;
    logic                                 route_err_q, route_err_d;

    logic [NB_MASTER-1:0] elig;
    logic [NB_MASTER-1:0] inc_vec;
    logic [NB_MASTER-1:0] dec_vec;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_found;
    logic                 can_load;
    logic [IDX_W-1:0]     r_idx;
    logic                 in_range;
    logic                 r_last_hs;

    assign s_ar_valid  = (state_q == FULL);
    assign s_ar_addr   = addr_q;
    assign s_ar_id     = id_q;
    assign route_err_o = route_err_q;

    assign r_idx    = s_r_id[SID_W-1 -: IDX_W];
    assign in_range = (int'(r_idx) < NB_MASTER);
    assign m_r_data = s_r_data;
    assign m_r_id   = s_r_id[AXI_ID_WIDTH-1:0];
    assign m_r_last = s_r_last;

    always_comb begin
        m_r_valid = '0;
        s_r_ready = 1'b1;
        if (in_range) begin
            m_r_valid[r_idx] = s_r_valid;
            s_r_ready        = m_r_ready[r_idx];
        end
    end

    assign r_last_hs   = s_r_valid & s_r_ready & s_r_last;
    assign route_err_d = s_r_valid & ~in_range;

    always_comb begin
        for (int i = 0; i < NB_MASTER; i++) begin
            elig[i] = m_ar_valid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
        end
    end

    // Search starts one past the last winner so every eligible master gets a turn.
    always_comb begin
        cand      = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 1; k <= NB_MASTER; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NB_MASTER);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign can_load = (state_q == EMPTY) || s_ar_ready;

    always_comb begin
        m_ar_ready = '0;
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        rr_ptr_d   = rr_ptr_q;
        if (rst_n && can_load && gnt_found) begin
            m_ar_ready[gnt_idx] = 1'b1;
            state_d             = FULL;
            addr_d              = m_ar_addr[gnt_idx];
            id_d                = {gnt_idx, m_ar_id[gnt_idx]};
            rr_ptr_d            = gnt_idx;
        end else if (state_q == FULL && s_ar_ready) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        outst_d = outst_q;
        for (int i = 0; i < NB_MASTER; i++) begin
            inc_vec[i] = m_ar_valid[i] & m_ar_ready[i];
            dec_vec[i] = r_last_hs & in_range & (r_idx == IDX_W'(i));
            if (inc_vec[i] && !dec_vec[i] && outst_q[i] < CNT_W'(MAX_OUTST)) begin
                outst_d[i] = outst_q[i] + CNT_W'(1);
            end else if (dec_vec[i] && !inc_vec[i] && outst_q[i] != '0) begin
                outst_d[i] = outst_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            addr_q      <= '0;
            id_q        <= '0;
            rr_ptr_q    <= IDX_W'(NB_MASTER - 1);
            outst_q     <= '0;
            route_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            outst_q     <= outst_d;
            route_err_q <= route_err_d;
        end
    end

endmodule
